rgb_stream_packer: RTL and testbench
====================================

RGB_STREAM_PACKER -- requirements
Module: rgb_stream_packer

Interface
REQ-001 Parameters: none; the line length is carried by eol, not by a parameter.
REQ-002 aclk  in  1  single clock for all logic.
REQ-003 aresetn  in  1  reset, synchronous, active-low.
REQ-004 r, g, b  in  8 each  pixel colour components.
REQ-005 valid  in  1  the pixel on r/g/b/sof/eol is presented.
REQ-006 sof  in  1  the pixel is the first of a frame.
REQ-007 eol  in  1  the pixel is the last of a line.
REQ-008 in_stream_ready  out  1  the block accepts a pixel this cycle.
REQ-009 out_stream_tdata  out  32  packed pixel bytes.
REQ-010 out_stream_tkeep  out  4  valid byte lanes.
REQ-011 out_stream_tlast  out  1  the word ends a line.
REQ-012 out_stream_tuser  out  1  the word starts a frame.
REQ-013 out_stream_tvalid  out  1  the output word is presented.
REQ-014 out_stream_tready  in  1  downstream accepts the word.

Function
REQ-015 A pixel SHALL be accepted when valid && in_stream_ready at a rising aclk edge.
REQ-016 A word SHALL be transferred when out_stream_tvalid && out_stream_tready.
REQ-017 Pixel value SHALL be P = {r,g,b}, 24 bits; bytes are emitted in the order b, g, r, filling lanes 0..3 in ascending order.
REQ-018 A residual register (0-3 bytes, count res_cnt) SHALL hold bytes not yet placed in a word.
REQ-019 Accept with res_cnt=0: no word; res_cnt becomes 3.
REQ-020 Accept with res_cnt=3: word {P[7:0],res[23:0]}; res_cnt becomes 2.
REQ-021 Accept with res_cnt=2: word {P[15:0],res[15:0]}; res_cnt becomes 1.
REQ-022 Accept with res_cnt=1: word {P[23:0],res[7:0]}; res_cnt becomes 0.
REQ-023 Every 4 pixels SHALL produce 3 words. A 1280-pixel line SHALL produce 960 words.
REQ-024 A single output register SHALL hold the presented word. tdata/tkeep/tlast/tuser SHALL stay stable while tvalid=1 and tready=0.
REQ-025 The output register SHALL load in the cycle after the accept that produces a word. Latency from pixel to word is 1 cycle.
REQ-026 State machine:
- States RUN and FLUSH; reset state is RUN.
- in_stream_ready SHALL be 1 only in RUN and when (!tvalid || tready).
REQ-027 eol accepted with remaining res_cnt=0: the produced word SHALL carry tlast=1 and tkeep=4'b1111.
REQ-028 eol accepted with remaining res_cnt>0:
- If a full word is produced, it carries tlast=0, and the block enters FLUSH.
- If no full word is produced (res_cnt was 0 before the accept), it enters FLUSH directly.
REQ-029 FLUSH:
- When the output register is free, load the residual, zero-padded in the upper lanes.
- tkeep = (1<<res_cnt)-1; tlast=1.
- Clear res_cnt to 0 and return to RUN.
REQ-030 tuser SHALL be 1 on the first word containing bytes of a pixel accepted with sof=1, and 0 otherwise.
REQ-031 sof accepted with res_cnt≠0: the residual bytes SHALL be discarded, and the sof pixel starts at lane 0 (res_cnt 0 → 3).
REQ-032 sof and eol on the same pixel SHALL give one word: tkeep=4'b0111, tuser=1, tlast=1.
REQ-033 A full word from a non-eol pixel SHALL carry tkeep=4'b1111 and tlast=0.
REQ-034 Pixels presented while in_stream_ready=0 SHALL be ignored; upstream holds them.

Reset
REQ-035 While aresetn=0 at an edge, the following SHALL be cleared on that edge:
- out_stream_tvalid=0, tdata=0, tkeep=0, tlast=0, tuser=0.
- res_cnt=0, state RUN.
REQ-036 in_stream_ready SHALL be 0 while aresetn=0 and 1 on the first cycle after release.
REQ-037 A reset mid-word SHALL discard residual bytes and any pending output word. No partial word is emitted after release.

Verification
REQ-038 Pixels 0x010203, 0x040506, 0x070809, 0x0A0B0C (sof on first, eol on last), tready=1 -> words 0x06010203 (tuser=1), 0x08090405, 0x0A0B0C07 (tlast=1), all tkeep=F.
REQ-039 Same stimulus, tready held 0 for 5 cycles after the first word -> word 0x06010203 stays stable, in_stream_ready=0, no pixel lost, same 3 words in order.
REQ-040 Pixels 0x010203, 0x040506 (eol on second) -> 0x06010203 tlast=0, then 0x00000405 tkeep=4'b0011 tlast=1; in_stream_ready=0 during FLUSH.
REQ-041 Full 1280x720 frame, random tready -> 691200 words, tlast every 960th word, exactly one tuser per frame.
REQ-042 Two pixels accepted, then aresetn=0 for 1 cycle, then 4 pixels with sof -> no leftover bytes appear; first word 0x06010203 with tuser=1.

Source files
------------

// File: rtl/rgb_stream_packer.sv
// -----------------------------------------------------------------------------
// rgb_stream_packer
//
// Packs a stream of 24-bit RGB pixels into a 32-bit AXI4-Stream style output.
// Pixel bytes go out in the order b, g, r and fill byte lanes 0..3 in
// ascending order. Four pixels therefore produce three full words. A line
// that ends part-way through a word is closed with one short word: the upper
// lanes are zero-filled, tkeep marks the live bytes, and tlast is set. tuser
// marks the first word that holds bytes of a start-of-frame pixel.
//
// Ports
//   aclk               in   1   clock for all logic
//   aresetn            in   1   synchronous reset, active-low
//   r, g, b            in   8   pixel colour components
//   valid              in   1   a pixel is presented on r/g/b/sof/eol
//   sof                in   1   the pixel is the first of a frame
//   eol                in   1   the pixel is the last of a line
//   in_stream_ready    out  1   a pixel is accepted this cycle if valid
//   out_stream_tdata   out  32  packed pixel bytes
//   out_stream_tkeep   out  4   live byte lanes
//   out_stream_tlast   out  1   the word ends a line
//   out_stream_tuser   out  1   the word starts a frame
//   out_stream_tvalid  out  1   the output word is presented
//   out_stream_tready  in   1   downstream accepts the word
// -----------------------------------------------------------------------------
module rgb_stream_packer (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  input  logic        valid,
  input  logic        sof,
  input  logic        eol,
  output logic        in_stream_ready,
  output logic [31:0] out_stream_tdata,
  output logic [3:0]  out_stream_tkeep,
  output logic        out_stream_tlast,
  output logic        out_stream_tuser,
  output logic        out_stream_tvalid,
  input  logic        out_stream_tready
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Full word from the incoming pixel and the held residual. Residual byte 0
  // always sits in lane 0, so the pixel fills the lanes above it.
  function automatic logic [31:0] pack_word(input logic [1:0]  cnt,
                                            input logic [23:0] pix,
                                            input logic [23:0] res);
    logic [31:0] w;
    w = '0;
    case (cnt)
      2'd3:    w = {pix[7:0],  res[23:0]};
      2'd2:    w = {pix[15:0], res[15:0]};
      2'd1:    w = {pix[23:0], res[7:0]};
      default: w = '0;
    endcase
    return w;
  endfunction

  // Pixel bytes left over after the word above has been formed,
  // right-aligned so the oldest leftover byte is lane 0 of the next word.
  function automatic logic [23:0] next_residual(input logic [1:0]  cnt,
                                                input logic [23:0] pix);
    logic [23:0] n;
    n = '0;
    case (cnt)
      2'd0:    n = pix;
      2'd3:    n = {8'h00,  pix[23:8]};
      2'd2:    n = {16'h0000, pix[23:16]};
      default: n = '0;
    endcase
    return n;
  endfunction

  // Short end-of-line word: live residual bytes, upper lanes zero.
  function automatic logic [31:0] pad_residual(input logic [1:0]  cnt,
                                               input logic [23:0] res);
    logic [31:0] w;
    w = '0;
    case (cnt)
      2'd1:    w = {24'h000000, res[7:0]};
      2'd2:    w = {16'h0000,   res[15:0]};
      2'd3:    w = {8'h00,      res[23:0]};
      default: w = '0;
    endcase
    return w;
  endfunction

  function automatic logic [3:0] keep_mask(input logic [1:0] cnt);
    logic [3:0] k;
    k = 4'b0000;
    case (cnt)
      2'd1:    k = 4'b0001;
      2'd2:    k = 4'b0011;
      2'd3:    k = 4'b0111;
      default: k = 4'b0000;
    endcase
    return k;
  endfunction

  state_t      state;
  logic [23:0] res_data;
  logic [1:0]  res_cnt;
  logic        sof_pend;

  logic [23:0] pix;
  logic        out_free;
  logic        accept;
  logic [1:0]  eff_cnt;
  logic        word_vld;
  logic [31:0] word_data;
  logic [23:0] res_nxt;
  logic [1:0]  cnt_nxt;
  logic        word_last;
  logic        go_flush;

  assign pix      = {r, g, b};
  assign out_free = !out_stream_tvalid || out_stream_tready;

  // Gated by aresetn so upstream sees no acceptance while reset is held.
  assign in_stream_ready = aresetn && (state == RUN) && out_free;
  assign accept          = valid && in_stream_ready;

  always_comb begin
    // A start-of-frame pixel throws away any leftover bytes and starts at
    // lane 0, which is the same as arriving with an empty residual.
    eff_cnt   = sof ? 2'd0 : res_cnt;
    word_vld  = (eff_cnt != 2'd0);
    word_data = pack_word(eff_cnt, pix, res_data);
    res_nxt   = next_residual(eff_cnt, pix);
    // 0->3, 3->2, 2->1, 1->0: every pixel adds three bytes and each full
    // word removes four, which is a decrement modulo 4.
    cnt_nxt   = eff_cnt - 2'd1;
    word_last = eol && (cnt_nxt == 2'd0);
    go_flush  = eol && (cnt_nxt != 2'd0);
  end

  // Stage p0 boundary: residual, state and the single output register.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state             <= RUN;
      res_cnt           <= 2'd0;
      sof_pend          <= 1'b0;
      out_stream_tvalid <= 1'b0;
      out_stream_tdata  <= '0;
      out_stream_tkeep  <= '0;
      out_stream_tlast  <= 1'b0;
      out_stream_tuser  <= 1'b0;
    end else begin
      // A transferred word leaves the register empty unless reloaded below.
      if (out_stream_tready) begin
        out_stream_tvalid <= 1'b0;
      end

      case (state)
        RUN: begin
          if (accept) begin
            res_data <= res_nxt;
            res_cnt  <= cnt_nxt;
            if (word_vld) begin
              out_stream_tvalid <= 1'b1;
              out_stream_tdata  <= word_data;
              out_stream_tkeep  <= 4'b1111;
              out_stream_tlast  <= word_last;
              out_stream_tuser  <= sof_pend;
              sof_pend          <= 1'b0;
            end
            // A sof pixel never completes a word itself (it starts at
            // lane 0), so its tuser waits for the next word out.
            if (sof) begin
              sof_pend <= 1'b1;
            end
            if (go_flush) begin
              state <= FLUSH;
            end
          end
        end

        FLUSH: begin
          if (out_free) begin
            out_stream_tvalid <= 1'b1;
            out_stream_tdata  <= pad_residual(res_cnt, res_data);
            out_stream_tkeep  <= keep_mask(res_cnt);
            out_stream_tlast  <= 1'b1;
            out_stream_tuser  <= sof_pend;
            sof_pend          <= 1'b0;
            res_cnt           <= 2'd0;
            state             <= RUN;
          end
        end

        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_stream_packer.sv
// -----------------------------------------------------------------------------
// tb_rgb_stream_packer
//
// Directed bench for rgb_stream_packer. Accepted pixels feed a byte-level
// reference model whose expected words go into a scoreboard queue; a monitor
// thread pops and compares each word as the DUT transfers it.
// -----------------------------------------------------------------------------
module tb_rgb_stream_packer;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [7:0]  r, g, b;
  logic        valid, sof, eol;
  logic        in_stream_ready;
  logic [31:0] out_stream_tdata;
  logic [3:0]  out_stream_tkeep;
  logic        out_stream_tlast;
  logic        out_stream_tuser;
  logic        out_stream_tvalid;
  logic        out_stream_tready;

  rgb_stream_packer dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .r                 (r),
    .g                 (g),
    .b                 (b),
    .valid             (valid),
    .sof               (sof),
    .eol               (eol),
    .in_stream_ready   (in_stream_ready),
    .out_stream_tdata  (out_stream_tdata),
    .out_stream_tkeep  (out_stream_tkeep),
    .out_stream_tlast  (out_stream_tlast),
    .out_stream_tuser  (out_stream_tuser),
    .out_stream_tvalid (out_stream_tvalid),
    .out_stream_tready (out_stream_tready)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic        user;
    logic        last;
    logic [3:0]  keep;
    logic [31:0] data;
  } word_t;

  int     vectors     = 0;
  int     miscompares = 0;
  word_t  exp_q[$];
  word_t  obs_log[$];
  logic [7:0] byte_q[$];
  logic   sof_flag    = 1'b0;
  bit     rand_tready = 1'b0;
  int     n_words     = 0;
  int     n_last      = 0;
  int     n_user      = 0;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic word_t obs_at(input int i);
    word_t w;
    w = '0;
    if (i < obs_log.size()) w = obs_log[i];
    return w;
  endfunction

  // Byte-queue reference: push b, g, r; every four queued bytes form a word.
  task automatic model_accept(input logic [23:0] p, input logic s, input logic e);
    word_t w;
    int    k;
    if (s) begin
      byte_q.delete();
      sof_flag = 1'b1;
    end
    byte_q.push_back(p[7:0]);
    byte_q.push_back(p[15:8]);
    byte_q.push_back(p[23:16]);
    while (byte_q.size() >= 4) begin
      w = '0;
      for (int i = 0; i < 4; i++) w.data[8*i +: 8] = byte_q.pop_front();
      w.keep = 4'hF;
      w.last = e && (byte_q.size() == 0);
      w.user = sof_flag;
      sof_flag = 1'b0;
      exp_q.push_back(w);
    end
    if (e && byte_q.size() > 0) begin
      w = '0;
      k = byte_q.size();
      for (int i = 0; i < k; i++) begin
        w.data[8*i +: 8] = byte_q.pop_front();
        w.keep[i] = 1'b1;
      end
      w.last = 1'b1;
      w.user = sof_flag;
      sof_flag = 1'b0;
      exp_q.push_back(w);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_pixel(input logic [23:0] p, input logic s, input logic e);
    int   n;
    logic acc;
    n = 0;
    acc = 1'b0;
    {r, g, b} = p;
    sof = s;
    eol = e;
    valid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge aclk);
      acc = in_stream_ready;
      @(posedge aclk);
      #1;
      n++;
    end
    if (acc) model_accept(p, s, e);
    else check("accept_timeout", 40'(n), 40'd0);
    valid = 1'b0;
    sof = 1'b0;
    eol = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() > 0 || out_stream_tvalid) && n < 5000) begin
      @(posedge aclk);
      #1;
      n++;
    end
    check("drain_queue", 40'(exp_q.size()), 40'd0);
    check("drain_tvalid", 40'(out_stream_tvalid), 40'd0);
  endtask

  initial begin
    int w0, l0, u0;
    aresetn = 1'b0;
    valid = 1'b0; sof = 1'b0; eol = 1'b0;
    r = '0; g = '0; b = '0;
    out_stream_tready = 1'b0;

    fork
      forever begin : monitor
        word_t e, o;
        @(negedge aclk);
        if (aresetn && out_stream_tvalid && out_stream_tready) begin
          o = {out_stream_tuser, out_stream_tlast, out_stream_tkeep, out_stream_tdata};
          obs_log.push_back(o);
          n_words++;
          if (out_stream_tlast) n_last++;
          if (out_stream_tuser) n_user++;
          if (exp_q.size() == 0) begin
            check("spurious_word_qsize", 40'(exp_q.size()), 40'd1);
          end else begin
            e = exp_q.pop_front();
            check("word", 40'(o), 40'(e));
          end
        end
      end
      forever begin : tready_gen
        @(posedge aclk);
        #1;
        if (rand_tready) out_stream_tready = 1'($urandom_range(0, 1));
      end
    join_none

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    @(negedge aclk);
    check("rst_ready", 40'(in_stream_ready), 40'd0);
    check("rst_tvalid", 40'(out_stream_tvalid), 40'd0);
    check("rst_tdata", 40'(out_stream_tdata), 40'd0);
    check("rst_tkeep", 40'(out_stream_tkeep), 40'd0);
    check("rst_tlast_tuser", 40'({out_stream_tlast, out_stream_tuser}), 40'd0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    check("ready_after_release", 40'(in_stream_ready), 40'd1);
    @(posedge aclk);
    #1;

    // Four pixels, one line, free-running output
    out_stream_tready = 1'b1;
    obs_log.delete();
    send_pixel(24'h010203, 1'b1, 1'b0);
    send_pixel(24'h040506, 1'b0, 1'b0);
    send_pixel(24'h070809, 1'b0, 1'b0);
    send_pixel(24'h0A0B0C, 1'b0, 1'b1);
    drain();
    check("t1_count", 40'(obs_log.size()), 40'd3);
    check("t1_w0", 40'(obs_at(0)), 40'({1'b1, 1'b0, 4'hF, 32'h06010203}));
    check("t1_w1", 40'(obs_at(1)), 40'({1'b0, 1'b0, 4'hF, 32'h08090405}));
    check("t1_w2", 40'(obs_at(2)), 40'({1'b0, 1'b1, 4'hF, 32'h0A0B0C07}));

    // Same line with the first word stalled for 5 cycles
    obs_log.delete();
    send_pixel(24'h010203, 1'b1, 1'b0);
    send_pixel(24'h040506, 1'b0, 1'b0);
    out_stream_tready = 1'b0;
    {r, g, b} = 24'h070809;
    valid = 1'b1;
    repeat (5) begin
      @(negedge aclk);
      check("stall_tdata", 40'(out_stream_tdata), 40'h06010203);
      check("stall_tvalid", 40'(out_stream_tvalid), 40'd1);
      check("stall_ready", 40'(in_stream_ready), 40'd0);
      @(posedge aclk);
      #1;
    end
    out_stream_tready = 1'b1;
    send_pixel(24'h070809, 1'b0, 1'b0);
    send_pixel(24'h0A0B0C, 1'b0, 1'b1);
    drain();
    check("t2_count", 40'(obs_log.size()), 40'd3);
    check("t2_w1", 40'(obs_at(1)), 40'({1'b0, 1'b0, 4'hF, 32'h08090405}));

    // Line ending with two residual bytes goes through FLUSH
    obs_log.delete();
    send_pixel(24'h010203, 1'b1, 1'b0);
    send_pixel(24'h040506, 1'b0, 1'b1);
    @(negedge aclk);
    check("flush_ready", 40'(in_stream_ready), 40'd0);
    @(posedge aclk);
    #1;
    drain();
    check("t3_w0", 40'(obs_at(0)), 40'({1'b1, 1'b0, 4'hF, 32'h06010203}));
    check("t3_w1", 40'(obs_at(1)), 40'({1'b0, 1'b1, 4'h3, 32'h00000405}));

    // sof and eol on one pixel
    obs_log.delete();
    send_pixel(24'h112233, 1'b1, 1'b1);
    drain();
    check("t4_w0", 40'(obs_at(0)), 40'({1'b1, 1'b1, 4'h7, 32'h00112233}));

    // sof mid-word discards the residual
    obs_log.delete();
    send_pixel(24'hAABBCC, 1'b0, 1'b0);
    send_pixel(24'h010203, 1'b1, 1'b0);
    send_pixel(24'h040506, 1'b0, 1'b0);
    send_pixel(24'h070809, 1'b0, 1'b0);
    send_pixel(24'h0A0B0C, 1'b0, 1'b1);
    drain();
    check("t5_count", 40'(obs_log.size()), 40'd3);
    check("t5_w0", 40'(obs_at(0)), 40'({1'b1, 1'b0, 4'hF, 32'h06010203}));

    // Reset with a residual byte pair and a pending word
    out_stream_tready = 1'b0;
    send_pixel(24'h515253, 1'b0, 1'b0);
    send_pixel(24'h545556, 1'b0, 1'b0);
    aresetn = 1'b0;
    exp_q.delete();
    byte_q.delete();
    sof_flag = 1'b0;
    @(negedge aclk);
    check("rst2_ready", 40'(in_stream_ready), 40'd0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    check("rst2_tvalid", 40'(out_stream_tvalid), 40'd0);
    check("rst2_ready_after", 40'(in_stream_ready), 40'd1);
    @(posedge aclk);
    #1;
    out_stream_tready = 1'b1;
    obs_log.delete();
    send_pixel(24'h010203, 1'b1, 1'b0);
    send_pixel(24'h040506, 1'b0, 1'b0);
    send_pixel(24'h070809, 1'b0, 1'b0);
    send_pixel(24'h0A0B0C, 1'b0, 1'b1);
    drain();
    check("t6_count", 40'(obs_log.size()), 40'd3);
    check("t6_w0", 40'(obs_at(0)), 40'({1'b1, 1'b0, 4'hF, 32'h06010203}));

    // Three 1280-pixel lines of one frame, random backpressure
    w0 = n_words;
    l0 = n_last;
    u0 = n_user;
    rand_tready = 1'b1;
    for (int ln = 0; ln < 3; ln++) begin
      for (int px = 0; px < 1280; px++) begin
        send_pixel(24'($urandom), (ln == 0) && (px == 0), px == 1279);
      end
    end
    rand_tready = 1'b0;
    out_stream_tready = 1'b1;
    drain();
    check("frame_words", 40'(n_words - w0), 40'd2880);
    check("frame_tlast", 40'(n_last - l0), 40'd3);
    check("frame_tuser", 40'(n_user - u0), 40'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
